// File: rtl/recv_program_fsm.sv
// recv_program_fsm: assembles UART bytes (MSB first) into instruction words and writes them to instruction memory.
// Ports: clk/rst (async, active-low) | i_start begins a load | i_rx_done/i_rx_data carry a received byte
//        o_inst_write_enable/o_inst_address/o_inst_data drive the memory write port
//        o_busy is high outside IDLE | o_done/o_error are one-cycle completion pulses
//        o_error_code (0 none, 1 timeout, 2 memory full) and o_inst_count are held until the next accepted start
module recv_program_fsm #(
  parameter int UART_BITS = 8,
  parameter int INSTRUCTION_BITS = 32,
  parameter int INST_ADDRS_BITS = 8,
  parameter logic [INSTRUCTION_BITS-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF,
  parameter int TIMEOUT_BITS = 24,
  parameter logic [TIMEOUT_BITS-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic                       i_rx_done,
  input  logic [UART_BITS-1:0]       i_rx_data,
  output logic                       o_inst_write_enable,
  output logic [INST_ADDRS_BITS-1:0] o_inst_address,
  output logic [INSTRUCTION_BITS-1:0] o_inst_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_error,
  output logic [1:0]                 o_error_code,
  output logic [INST_ADDRS_BITS:0]   o_inst_count
);
  localparam int NBYTES = INSTRUCTION_BITS / UART_BITS;
  localparam int BW = $clog2(NBYTES) + 1;
  localparam int CW = INST_ADDRS_BITS + 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
  localparam logic [TIMEOUT_BITS-1:0] TMO_LAST = TIMEOUT_CYCLES - TIMEOUT_BITS'(1);

  typedef enum logic [2:0] {IDLE, WAIT_BYTE, WRITE_INST, FINISH, ERROR} state_t;

  state_t                      state_q, state_d;
  logic [INST_ADDRS_BITS-1:0]  addr_q, addr_d;
  logic [BW-1:0]               bcnt_q, bcnt_d;
  logic [INSTRUCTION_BITS-1:0] word_q, word_d;
  logic [TIMEOUT_BITS-1:0]     tmo_q, tmo_d;
  logic [1:0]                  code_q, code_d;
  logic [CW-1:0]               cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      tmo_q   <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    tmo_d   = tmo_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (i_start) begin
        addr_d  = '0;
        bcnt_d  = '0;
        word_d  = '0;
        tmo_d   = '0;
        code_d  = '0;
        cnt_d   = '0;
        state_d = WAIT_BYTE;
      end
      WAIT_BYTE: if (i_rx_done) begin
        word_d  = {word_q[INSTRUCTION_BITS-UART_BITS-1:0], i_rx_data};
        bcnt_d  = bcnt_q + BW'(1);
        tmo_d   = '0;
        state_d = bcnt_q == LAST_BYTE ? WRITE_INST : WAIT_BYTE;
      end else begin
        tmo_d = tmo_q + TIMEOUT_BITS'(1);
        if (TIMEOUT_CYCLES != '0 && tmo_q == TMO_LAST) begin
          // addr_q equals the number of words already written
          cnt_d   = {1'b0, addr_q};
          code_d  = 2'd1;
          state_d = ERROR;
        end
      end
      WRITE_INST: if (word_q == HALT_INSTRUCTION) begin
        cnt_d   = {1'b0, addr_q} + CW'(1);
        state_d = FINISH;
      end else if (&addr_q) begin
        cnt_d   = {1'b0, addr_q} + CW'(1);
        code_d  = 2'd2;
        state_d = ERROR;
      end else begin
        addr_d  = addr_q + INST_ADDRS_BITS'(1);
        bcnt_d  = '0;
        tmo_d   = '0;
        state_d = WAIT_BYTE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy              = state_q != IDLE;
  assign o_inst_write_enable = state_q == WRITE_INST;
  assign o_inst_address      = o_inst_write_enable ? addr_q : '0;
  assign o_inst_data         = o_inst_write_enable ? word_q : '0;
  assign o_done              = state_q == FINISH;
  assign o_error             = state_q == ERROR;
  assign o_error_code        = code_q;
  assign o_inst_count        = cnt_q;
endmodule

// File: doc/recv_program_fsm.md
Name: recv_program_fsm

Overview:
- Debug-unit receive path: takes bytes from the UART receiver and assembles them into INSTRUCTION_BITS-wide words, MSB byte first.
- Writes each word into instruction memory at consecutive addresses from 0.
- Stops on the HALT word or on an error, then reports completion and the loaded word count to the debug-unit controller.
- It is the load-side counterpart of the debug dump/transmit FSM.

Parameters:
UART_BITS, 8, width of one UART byte
INSTRUCTION_BITS, 32, instruction word width; must be a multiple of UART_BITS
INST_ADDRS_BITS, 8, instruction memory address width (2^INST_ADDRS_BITS words)
HALT_INSTRUCTION, 32'hFFFF_FFFF, word value that terminates loading (it is also written)
TIMEOUT_BITS, 24, width of the inter-byte timeout counter
TIMEOUT_CYCLES, 24'd10_000_000, max idle cycles in WAIT_BYTE before abort; 0 disables timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
i_start  in  1  one-cycle pulse: begin a program load
i_rx_done  in  1  one-cycle pulse from UART receiver: i_rx_data valid
i_rx_data  in  UART_BITS  received byte
o_inst_write_enable  out  1  instruction memory write strobe
o_inst_address  out  INST_ADDRS_BITS  write address
o_inst_data  out  INSTRUCTION_BITS  write data
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse: load completed with HALT
o_error  out  1  one-cycle pulse: load aborted
o_error_code  out  2  0 none, 1 timeout, 2 memory full; held until next accepted i_start
o_inst_count  out  INST_ADDRS_BITS+1  words written in the last load, HALT included; held until next accepted i_start

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs, address, byte count, assembly register and timeout counter cleared to 0. A reset mid-load abandons the load; no further writes occur.
- NBYTES = INSTRUCTION_BITS/UART_BITS (4 by default).
- IDLE:
  - Outputs 0, except o_error_code and o_inst_count, which are held.
  - i_start=1 clears address, byte_count, assembly word, timeout, o_error_code and o_inst_count, then goes to WAIT_BYTE.
  - i_rx_done in IDLE is ignored.
- WAIT_BYTE, on i_rx_done=1:
  - word <= {word[INSTRUCTION_BITS-UART_BITS-1:0], i_rx_data}; byte_count++; timeout <= 0.
  - If byte_count was NBYTES-1, go to WRITE_INST; else stay.
- WAIT_BYTE, with no byte:
  - timeout increments.
  - If TIMEOUT_CYCLES != 0 and timeout == TIMEOUT_CYCLES-1, go to ERROR with code 1. The partial word is discarded.
  - The timeout applies before the first byte too.
- WRITE_INST (exactly one cycle):
  - Drives o_inst_write_enable=1, o_inst_address=address, o_inst_data=word, all combinational from state.
  - Same-cycle decision, in this priority:
    - word == HALT_INSTRUCTION: o_inst_count <= address+1, go to FINISH.
    - else address == all-ones: o_inst_count <= address+1, go to ERROR with code 2. The last word is still written.
    - else address++, byte_count <= 0, timeout <= 0, go to WAIT_BYTE.
- FINISH: o_done=1 for one cycle, then IDLE.
- ERROR: o_error=1 for one cycle, then IDLE.
- Bytes arriving in WRITE_INST, FINISH or ERROR are dropped. The host paces bytes at UART rate, so this cannot occur in legal operation.
- i_start while o_busy=1 is ignored.
- Latency: write strobe asserts the cycle after the i_rx_done of the last byte of a word. o_done asserts the cycle after the HALT write.
- o_inst_count is 0 after a timeout on the first word. Otherwise it equals the number of writes performed.
- Address never wraps: the memory-full abort prevents wrap to 0.

Test Plan:
- Reset then start; send 04 03 02 01, AA BB CC DD, FF FF FF FF -> three writes: addr0=0x04030201, addr1=0xAABBCCDD, addr2=0xFFFFFFFF; o_done pulse one cycle after third write; o_inst_count=3; o_error_code=0.
- TIMEOUT_CYCLES=100; start, send 12 34 then stop -> no write; o_error pulse 100 cycles after the byte-2 i_rx_done; code 1; o_inst_count=0; next start clears code to 0.
- INST_ADDRS_BITS=2; send 4 non-HALT words -> writes at addrs 0-3; o_error after addr3 write; code 2; o_inst_count=4.
- Assert rst low mid-word (after 2 bytes) -> all outputs 0 immediately, no write; after release, fresh load of one HALT word gives single write at addr0, o_inst_count=1.
- i_start pulses during WAIT_BYTE and i_rx_done pulses in IDLE -> no effect on address/count; load completes identically to the first scenario.
- Back-to-back bytes (i_rx_done every cycle for 4 cycles) -> correct word assembled, write strobe exactly one cycle wide.
